fmul_arbiter: RTL

Round-robin arbiter that shares one pipelined `fmul` unit (3-cycle latency, no backpressure) among `NREQ` requesters.
- Each requester has a valid/ready request port and a valid/ready response port.
- Requester IDs travel through a tag pipeline aligned to the multiplier's latency, so results are routed back to the requester that issued them.
- Per-requester credit counters guarantee a returning result always has a response-FIFO slot, because `fmul` cannot be stalled.
- Sits between the core/FPU dispatch logic and the `fmul` instance.

---
 rtl/fmul_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one pipelined fmul among NREQ requesters.
// Define FMUL_ARB_FLAGS_EN to carry ovf/unf through the response FIFOs.
module fmul_arbiter #(
    parameter int NREQ       = 2,
    parameter int LATENCY    = 3,
    parameter int RESP_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [32*NREQ-1:0]   resp_y,
    output logic [NREQ-1:0]      resp_ovf,
    output logic [NREQ-1:0]      resp_unf,
    output logic                 fmul_valid,
    output logic [31:0]          fmul_x1,
    output logic [31:0]          fmul_x2,
    input  logic [31:0]          fmul_y,
    input  logic                 fmul_ovf,
    input  logic                 fmul_unf,
    input  logic                 fmul_out_valid,
    output logic                 err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(RESP_DEPTH + 1);
    localparam int AW  = $clog2(RESP_DEPTH);
`ifdef FMUL_ARB_FLAGS_EN
    localparam int EW  = 34;
`else
    localparam int EW  = 32;
`endif

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic            w_any;
    logic [IDW-1:0]  w_gid;
    logic [31:0]     w_x1;
    logic [31:0]     w_x2;
    logic [IDW-1:0]  r_ptr;
    logic [EW-1:0]   w_wdata;

    logic [LATENCY:0] r_tv;
    logic [IDW-1:0]   r_tid [LATENCY+1];
    logic             r_err;
    logic             r_fv;
    logic [31:0]      r_fx1;
    logic [31:0]      r_fx2;

    // Rotating priority search starting at r_ptr, wrapping at NREQ.
    always_comb begin
        int s;
        logic [IDW-1:0] idx;
        w_any = 1'b0;
        w_gid = '0;
        w_gnt = '0;
        w_x1  = '0;
        w_x2  = '0;
        s     = 0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(r_ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            idx = IDW'(s);
            if (!w_any && w_elig[idx]) begin
                w_any = 1'b1;
                w_gid = idx;
                w_x1  = req_x1[32*s +: 32];
                w_x2  = req_x2[32*s +: 32];
            end
        end
        if (w_any) w_gnt[w_gid] = 1'b1;
    end

    assign req_ready = w_gnt;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_fv  <= 1'b0;
            r_fx1 <= '0;
            r_fx2 <= '0;
        end else begin
            r_fv <= w_any;
            if (w_any) begin
                r_fx1 <= w_x1;
                r_fx2 <= w_x2;
                r_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);
            end
        end
    end

    assign fmul_valid = r_fv;
    assign fmul_x1    = r_fx1;
    assign fmul_x2    = r_fx2;

    // Last tag stage lines up with fmul_out_valid.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_tv <= '0;
            for (int k = 0; k <= LATENCY; k++) r_tid[k] <= '0;
            r_err <= 1'b0;
        end else begin
            r_tv     <= {r_tv[LATENCY-1:0], w_any};
            r_tid[0] <= w_gid;
            for (int k = 1; k <= LATENCY; k++) r_tid[k] <= r_tid[k-1];
            if (fmul_out_valid != r_tv[LATENCY]) r_err <= 1'b1;
        end
    end

    assign err = r_err;

`ifdef FMUL_ARB_FLAGS_EN
    assign w_wdata = {fmul_ovf, fmul_unf, fmul_y};
`else
    logic w_unused_flags;
    assign w_unused_flags = fmul_ovf ^ fmul_unf;
    assign w_wdata = fmul_y;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        logic [AW:0]     r_wp;
        logic [AW:0]     r_rp;
        logic [CW-1:0]   r_out;
        logic [EW-1:0]   r_mem [RESP_DEPTH];
        logic            w_empty;
        logic            w_full;
        logic            w_push;
        logic            w_pop;
        logic [EW-1:0]   w_head;

        assign w_empty = (r_wp == r_rp);
        assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                         (r_wp[AW-1:0] == r_rp[AW-1:0]);
        assign w_pop   = resp_ready[i] && !w_empty;
        assign w_push  = r_tv[LATENCY] &&
                         (r_tid[LATENCY] == IDW'(i)) &&
                         (!w_full || w_pop);
        assign w_elig[i] = !rst && req_valid[i] &&
                           (r_out < CW'(RESP_DEPTH));

        // Credits cover both in-flight tags and FIFO occupancy.
        always_ff @(posedge sys_clk) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_out <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + (AW+1)'(1);
                if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
                unique case ({w_gnt[i], w_pop})
                    2'b10:   r_out <= r_out + CW'(1);
                    2'b01:   r_out <= r_out - CW'(1);
                    default: r_out <= r_out;
                endcase
            end
        end

        always_ff @(posedge sys_clk) begin
            if (w_push) r_mem[r_wp[AW-1:0]] <= w_wdata;
        end

        assign w_head        = r_mem[r_rp[AW-1:0]];
        assign resp_valid[i] = !w_empty;
        assign resp_y[32*i +: 32] = w_empty ? 32'd0 : w_head[31:0];
`ifdef FMUL_ARB_FLAGS_EN
        assign resp_ovf[i] = !w_empty && w_head[33];
        assign resp_unf[i] = !w_empty && w_head[32];
`endif
    end

`ifndef FMUL_ARB_FLAGS_EN
    assign resp_ovf = '0;
    assign resp_unf = '0;
`endif

endmodule
